// File: rtl/mem_if_v2_pkg.sv
// Shared types and defaults for the mem_if_v2 storage block.
// The parity helper is only referenced when MEM_IF_V2_PARITY_EN is defined.
package mem_if_v2_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_DATA_W   = 1;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_INIT_VAL = 0;

    // Even parity: the returned bit makes the total number of ones even.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mem_if_v2_array.sv
// DEPTH x WORD_W storage with one write port and a combinational read port.
// A same-cycle write to the read address is forwarded (write-first).
module mem_if_v2_array #(
    parameter int ADDR_W = 3,
    parameter int WORD_W = 1,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [ADDR_W-1:0] rd_addr,
`ifdef MEM_IF_V2_PARITY_EN
    output logic              rd_bypass,
`endif
    output logic [WORD_W-1:0] rd_word
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic              hit;

    // NOTE: the array has no reset; the init sweep gives every entry a defined value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    assign hit     = wr_en && (wr_addr == rd_addr);
    assign rd_word = hit ? wr_word : mem[rd_addr];

`ifdef MEM_IF_V2_PARITY_EN
    assign rd_bypass = hit;
`endif

endmodule

// File: rtl/mem_if_v2.sv
// Method-style memory with en/rdy handshakes, registered read and an init sweep.
// Define MEM_IF_V2_PARITY_EN to add per-entry even parity, err_inject and read_err.
module mem_if_v2
    import mem_if_v2_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(DEF_INIT_VAL)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_en,
    output logic              write_rdy,
    input  logic [ADDR_W-1:0] read_address,
    input  logic              read_en,
    output logic              read_rdy,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
`ifdef MEM_IF_V2_PARITY_EN
    input  logic              err_inject,
    output logic              read_err,
`endif
    input  logic              clear_en,
    output logic              clear_rdy,
    output logic              busy
);

`ifdef MEM_IF_V2_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif
    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  sweep_q, sweep_d;
    logic              ready, write_fire, read_fire;
    logic              wr_in_range, rd_in_range;
    logic              arr_wr_en;
    logic [ADDR_W-1:0] arr_wr_addr;
    logic [WORD_W-1:0] arr_wr_word, init_word, user_word, rd_word;

    assign ready       = (state_q == READY);
    assign write_rdy   = ready;
    assign read_rdy    = ready;
    assign clear_rdy   = ready;
    assign busy        = !ready;
    assign write_fire  = write_en && ready;
    assign read_fire   = read_en && ready;
    assign wr_in_range = int'(write_address) < DEPTH;
    assign rd_in_range = int'(read_address) < DEPTH;

`ifdef MEM_IF_V2_PARITY_EN
    logic rd_bypass;
    assign init_word = {even_parity(64'(INIT_VAL)), INIT_VAL};
    assign user_word = {even_parity(64'(write_data)) ^ err_inject, write_data};
`else
    assign init_word = INIT_VAL;
    assign user_word = write_data;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        arr_wr_en   = 1'b0;
        arr_wr_addr = write_address;
        arr_wr_word = user_word;
        if (!ready) begin
            arr_wr_en   = 1'b1;
            arr_wr_addr = ADDR_W'(sweep_q);
            arr_wr_word = init_word;
        end else if (write_fire && wr_in_range) begin
            arr_wr_en = 1'b1;
        end
    end

    mem_if_v2_array #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk       (CLK),
        .wr_en     (arr_wr_en),
        .wr_addr   (arr_wr_addr),
        .wr_word   (arr_wr_word),
        .rd_addr   (read_address),
`ifdef MEM_IF_V2_PARITY_EN
        .rd_bypass (rd_bypass),
`endif
        .rd_word   (rd_word)
    );

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            INIT: begin
                // The pointer parks on the last entry; clear re-arms it to zero.
                if (sweep_q == LAST_PTR) begin
                    state_d = READY;
                end else begin
                    sweep_d = sweep_q + PTR_W'(1);
                end
            end
            READY: begin
                if (clear_en) begin
                    state_d = INIT;
                    sweep_d = '0;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= read_fire;
            if (read_fire) begin
                read_data <= rd_in_range ? rd_word[DATA_W-1:0] : '0;
            end
        end
    end

`ifdef MEM_IF_V2_PARITY_EN
    // A forwarded word carries freshly computed parity, so it never flags an error.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            read_err <= 1'b0;
        end else begin
            read_err <= read_fire && rd_in_range && !rd_bypass &&
                        (rd_word[DATA_W] != even_parity(64'(rd_word[DATA_W-1:0])));
        end
    end
`endif

endmodule

// File: tb/tb_mem_if_v2.sv
// Scoreboard bench for mem_if_v2 (ADDR_W=3, DATA_W=8, DEPTH=8, INIT_VAL=8'hA5).
// Parity checks are enabled when MEM_IF_V2_PARITY_EN is defined.
module tb_mem_if_v2;

    localparam int          ADDR_W   = 3;
    localparam int          DATA_W   = 8;
    localparam int          DEPTH    = 8;
    localparam logic [7:0]  INIT_VAL = 8'hA5;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b1;
    logic [ADDR_W-1:0] write_address = '0;
    logic [DATA_W-1:0] write_data = '0;
    logic              write_en = 1'b0;
    logic              write_rdy;
    logic [ADDR_W-1:0] read_address = '0;
    logic              read_en = 1'b0;
    logic              read_rdy;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              clear_en = 1'b0;
    logic              clear_rdy;
    logic              busy;
`ifdef MEM_IF_V2_PARITY_EN
    logic              err_inject = 1'b0;
    logic              read_err;
`endif

    exp_t       exp_q[$];
    logic [7:0] model_mem [DEPTH];
    logic       model_perr [DEPTH];
    logic [7:0] last_rd;
    int         busy_cnt;
    int         checks = 0;
    int         errors = 0;

    mem_if_v2 #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_rdy      (read_rdy),
        .read_data     (read_data),
        .read_valid    (read_valid),
`ifdef MEM_IF_V2_PARITY_EN
        .err_inject    (err_inject),
        .read_err      (read_err),
`endif
        .clear_en      (clear_en),
        .clear_rdy     (clear_rdy),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sweep_model();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]  = INIT_VAL;
            model_perr[i] = 1'b0;
        end
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic step(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic re, input logic [2:0] ra, input logic ce, input logic ei);
        bit   exp_busy;
        bit   exp_valid;
        exp_t e;
        exp_busy = (busy_cnt > 0);
        check("busy", busy, exp_busy);
        check("write_rdy", write_rdy, !exp_busy);
        check("read_rdy", read_rdy, !exp_busy);
        check("clear_rdy", clear_rdy, !exp_busy);
        write_en      = we;
        write_address = wa;
        write_data    = wd;
        read_en       = re;
        read_address  = ra;
        clear_en      = ce;
`ifdef MEM_IF_V2_PARITY_EN
        err_inject    = ei;
`endif
        exp_valid = 1'b0;
        if (!exp_busy) begin
            if (we) begin
                model_mem[wa]  = wd;
                model_perr[wa] = ei;
            end
            if (re) begin
                e.data = model_mem[ra];
                e.err  = (we && wa == ra) ? 1'b0 : model_perr[ra];
                exp_q.push_back(e);
                exp_valid = 1'b1;
            end
            if (ce) begin
                sweep_model();
                busy_cnt = DEPTH;
            end
        end else begin
            busy_cnt--;
        end
        @(posedge CLK);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        clear_en = 1'b0;
`ifdef MEM_IF_V2_PARITY_EN
        err_inject = 1'b0;
`endif
        @(negedge CLK);
        check("read_valid", read_valid, exp_valid);
        if (read_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_depth", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                check("read_data", read_data, e.data);
`ifdef MEM_IF_V2_PARITY_EN
                check("read_err", read_err, e.err);
`endif
                last_rd = e.data;
            end
        end else begin
            check("read_hold", read_data, last_rd);
`ifdef MEM_IF_V2_PARITY_EN
            check("read_err_idle", read_err, 0);
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        busy_cnt = DEPTH;
        sweep_model();
        last_rd = 8'h00;
    endtask

    initial begin
        busy_cnt = DEPTH;
        last_rd  = 8'h00;
        #1 RST_N = 1'b0;
        #1;
        check("rst_read_data", read_data, 0);
        check("rst_read_valid", read_valid, 0);
        check("rst_busy", busy, 1);
        check("rst_rdy", {write_rdy, read_rdy, clear_rdy}, 0);
        release_reset();

        // Init sweep: busy for exactly DEPTH cycles, then every entry reads INIT_VAL.
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 3'(i), 0, 0);

        // Write then read.
        step(1, 3, 8'h3C, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 0, 0);

        // Same-cycle write and read to one address.
        step(1, 5, 8'h77, 1, 5, 0, 0);
        step(0, 0, 0, 1, 5, 0, 0);

        // Clear; methods (including a second clear) are ignored during the sweep.
        step(1, 1, 8'h11, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 1, 8'hFF, 1, 1, (i == 3), 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 3, 0, 0);

        // Clear together with write and read: read sees the write, sweep wins afterwards.
        step(1, 6, 8'h66, 1, 6, 1, 0);
        idle(DEPTH);
        step(0, 0, 0, 1, 6, 0, 0);

        // Mixed traffic.
        for (int i = 0; i < 24; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 0, 0);
        end

        // Reset in the cycle after a read is accepted.
        step(1, 2, 8'h5A, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2, 0, 0);
        #2 RST_N = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_read_valid", read_valid, 0);
        check("midrst_read_data", read_data, 0);
        check("midrst_busy", busy, 1);
        check("midrst_rdy", {write_rdy, read_rdy, clear_rdy}, 0);
        release_reset();
        idle(DEPTH);
        step(0, 0, 0, 1, 2, 0, 0);

`ifdef MEM_IF_V2_PARITY_EN
        // Parity: injected error on store, clean store, and injected error on a bypassed read.
        step(1, 2, 8'h0F, 0, 0, 0, 1);
        step(0, 0, 0, 1, 2, 0, 0);
        step(1, 4, 8'h0F, 0, 0, 0, 0);
        step(0, 0, 0, 1, 4, 0, 0);
        step(1, 7, 8'h33, 1, 7, 0, 1);
        step(0, 0, 0, 1, 7, 0, 0);
`endif

        idle(2);
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
